// File: rtl/rggen_bit_field_event_capture_if.sv
// Register bit-field bus between the register block and one bit field.
// The master side issues write requests; the bit field returns its value.
interface rggen_bit_field_event_capture_if #(
   parameter int WIDTH = 1
);
   logic             valid;
   logic [WIDTH-1:0] write_mask;
   logic [WIDTH-1:0] write_data;
   logic [WIDTH-1:0] read_data;
   logic [WIDTH-1:0] value;

   modport master (
      output valid,
      output write_mask,
      output write_data,
      input  read_data,
      input  value
   );

   modport slave (
      input  valid,
      input  write_mask,
      input  write_data,
      output read_data,
      output value
   );

   modport bit_field (
      input  valid,
      input  write_mask,
      input  write_data,
      output read_data,
      output value
   );
endinterface

// File: rtl/rggen_bit_field_event_capture.sv
// Event-capture bit field: hardware events set sticky status bits, software
// clears them through the bit-field bus. Per-bit overflow flags record an
// event arriving on a bit that was already set; o_irq is a registered OR of
// enabled status bits.
module rggen_bit_field_event_capture #(
   parameter int               WIDTH         = 1,
   parameter bit               CLEAR_VALUE   = 1'b1,
   parameter bit               EDGE_DETECT   = 1'b1,
   parameter bit               SET_PRIORITY  = 1'b1,
   parameter logic [WIDTH-1:0] INITIAL_VALUE = '0
) (
   input  logic                                   i_clk,
   input  logic                                   i_rst,
   rggen_bit_field_event_capture_if.bit_field     bit_field_if,
   input  logic [WIDTH-1:0]                       i_event,
   input  logic [WIDTH-1:0]                       i_enable,
   output logic [WIDTH-1:0]                       o_status,
   output logic [WIDTH-1:0]                       o_overflow,
   output logic                                   o_irq
);

   logic [WIDTH-1:0] status;
   logic [WIDTH-1:0] overflow;
   logic [WIDTH-1:0] event_d;
   logic             irq;

   logic [WIDTH-1:0] set_req;
   logic [WIDTH-1:0] clear_req;
   logic [WIDTH-1:0] clear_data;
   logic [WIDTH-1:0] status_next;
   logic [WIDTH-1:0] overflow_next;

   // Decode set/clear requests and resolve the next status and overflow.
   always_comb begin
      set_req       = '0;
      clear_req     = '0;
      clear_data    = '0;
      status_next   = status;
      overflow_next = overflow;

      if (EDGE_DETECT) begin
         set_req = i_event & ~event_d;
      end else begin
         set_req = i_event;
      end

      clear_data = CLEAR_VALUE ? bit_field_if.write_data : ~bit_field_if.write_data;
      if (bit_field_if.valid) begin
         clear_req = bit_field_if.write_mask & clear_data;
      end

      if (SET_PRIORITY) begin
         status_next = (status & ~clear_req) | set_req;
      end else begin
         status_next = (status | set_req) & ~clear_req;
      end

      // A clear always drops the overflow flag, even when the set wins on status.
      overflow_next = (overflow | (set_req & status)) & ~clear_req;
   end

   // State registers; irq is taken from the current status, so it lags status by one edge.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         status   <= INITIAL_VALUE;
         overflow <= '0;
         event_d  <= '0;
         irq      <= 1'b0;
      end else begin
         status   <= status_next;
         overflow <= overflow_next;
         event_d  <= i_event;
         irq      <= |(status & i_enable);
      end
   end

   assign bit_field_if.read_data = status;
   assign bit_field_if.value     = status;
   assign o_status               = status;
   assign o_overflow             = overflow;
   assign o_irq                  = irq;

endmodule

// File: tb/tb_rggen_bit_field_event_capture.sv
// Bench for the event-capture bit field. Three parameter sets share one
// stimulus stream; a per-bit behavioural model predicts every output.
//   cfg0: write-1-to-clear, edge, set wins,   reset value 0010
//   cfg1: write-0-to-clear, edge, clear wins, reset value 0010
//   cfg2: write-1-to-clear, level, clear wins, reset value 0000
module tb_rggen_bit_field_event_capture;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic [W-1:0] ev;
   logic [W-1:0] en;

   logic [W-1:0] st   [3];
   logic [W-1:0] ovf  [3];
   logic         irq  [3];

   int checks = 0;
   int errors = 0;

   // model configuration and state
   bit           cfg_cv   [3] = '{1'b1, 1'b0, 1'b1};
   bit           cfg_edge [3] = '{1'b1, 1'b1, 1'b0};
   bit           cfg_sp   [3] = '{1'b1, 1'b0, 1'b0};
   logic [W-1:0] cfg_init [3] = '{4'b0010, 4'b0010, 4'b0000};

   logic [W-1:0] m_st  [3];
   logic [W-1:0] m_ovf [3];
   logic [W-1:0] m_evd [3];
   logic         m_irq [3];

   // bus request expressed as "which bits software wants to clear"
   logic         req_valid;
   logic [W-1:0] req_mask;
   logic [W-1:0] req_clear;

   rggen_bit_field_event_capture_if #(.WIDTH(W)) bf0 ();
   rggen_bit_field_event_capture_if #(.WIDTH(W)) bf1 ();
   rggen_bit_field_event_capture_if #(.WIDTH(W)) bf2 ();

   always #5 clk = ~clk;

   rggen_bit_field_event_capture #(
      .WIDTH(W), .CLEAR_VALUE(1'b1), .EDGE_DETECT(1'b1), .SET_PRIORITY(1'b1), .INITIAL_VALUE(4'b0010)
   ) dut0 (
      .i_clk(clk), .i_rst(rst), .bit_field_if(bf0.bit_field), .i_event(ev), .i_enable(en),
      .o_status(st[0]), .o_overflow(ovf[0]), .o_irq(irq[0])
   );

   rggen_bit_field_event_capture #(
      .WIDTH(W), .CLEAR_VALUE(1'b0), .EDGE_DETECT(1'b1), .SET_PRIORITY(1'b0), .INITIAL_VALUE(4'b0010)
   ) dut1 (
      .i_clk(clk), .i_rst(rst), .bit_field_if(bf1.bit_field), .i_event(ev), .i_enable(en),
      .o_status(st[1]), .o_overflow(ovf[1]), .o_irq(irq[1])
   );

   rggen_bit_field_event_capture #(
      .WIDTH(W), .CLEAR_VALUE(1'b1), .EDGE_DETECT(1'b0), .SET_PRIORITY(1'b0), .INITIAL_VALUE(4'b0000)
   ) dut2 (
      .i_clk(clk), .i_rst(rst), .bit_field_if(bf2.bit_field), .i_event(ev), .i_enable(en),
      .o_status(st[2]), .o_overflow(ovf[2]), .o_irq(irq[2])
   );

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   // Apply a bus request; the raw write data depends on each instance's clear polarity.
   task automatic drive_bus(input logic v, input logic [W-1:0] mask, input logic [W-1:0] clr);
      req_valid = v;
      req_mask  = mask;
      req_clear = clr;
      bf0.valid = v; bf0.write_mask = mask; bf0.write_data = cfg_cv[0] ? clr : ~clr;
      bf1.valid = v; bf1.write_mask = mask; bf1.write_data = cfg_cv[1] ? clr : ~clr;
      bf2.valid = v; bf2.write_mask = mask; bf2.write_data = cfg_cv[2] ? clr : ~clr;
   endtask

   // Reference model: one clock edge, bit by bit from the field's rules.
   task automatic model_edge();
      for (int c = 0; c < 3; c++) begin
         logic [W-1:0] wd;
         logic [W-1:0] ns;
         logic [W-1:0] no;
         logic         ni;
         wd = (c == 0) ? bf0.write_data : (c == 1) ? bf1.write_data : bf2.write_data;
         ni = 1'b0;
         for (int b = 0; b < W; b++) begin
            bit s, k;
            if (en[b] && m_st[c][b]) ni = 1'b1;
            s = cfg_edge[c] ? (ev[b] && !m_evd[c][b]) : ev[b];
            k = req_valid && req_mask[b] && (wd[b] == cfg_cv[c]);
            if (s && k)      ns[b] = cfg_sp[c];
            else if (s)      ns[b] = 1'b1;
            else if (k)      ns[b] = 1'b0;
            else             ns[b] = m_st[c][b];
            if (k)                     no[b] = 1'b0;
            else if (s && m_st[c][b])  no[b] = 1'b1;
            else                       no[b] = m_ovf[c][b];
         end
         if (rst) begin
            m_st[c]  = cfg_init[c];
            m_ovf[c] = '0;
            m_evd[c] = '0;
            m_irq[c] = 1'b0;
         end else begin
            m_st[c]  = ns;
            m_ovf[c] = no;
            m_evd[c] = ev;
            m_irq[c] = ni;
         end
      end
   endtask

   task automatic model_check();
      logic [W-1:0] rd [3];
      logic [W-1:0] vl [3];
      rd[0] = bf0.read_data; rd[1] = bf1.read_data; rd[2] = bf2.read_data;
      vl[0] = bf0.value;     vl[1] = bf1.value;     vl[2] = bf2.value;
      for (int c = 0; c < 3; c++) begin
         check($sformatf("cfg%0d_status", c),    st[c],          m_st[c]);
         check($sformatf("cfg%0d_overflow", c),  ovf[c],         m_ovf[c]);
         check($sformatf("cfg%0d_irq", c),       {3'b000, irq[c]}, {3'b000, m_irq[c]});
         check($sformatf("cfg%0d_read_data", c), rd[c],          m_st[c]);
         check($sformatf("cfg%0d_value", c),     vl[c],          m_st[c]);
      end
   endtask

   // One clock edge: model follows the edge, outputs sampled 1 time unit later.
   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      model_check();
   endtask

   initial begin
      for (int c = 0; c < 3; c++) begin
         m_st[c] = 'x; m_ovf[c] = 'x; m_evd[c] = 'x; m_irq[c] = 1'bx;
      end
      rst = 1'b1;
      ev  = 4'b0001;
      en  = 4'b0000;
      drive_bus(1'b0, 4'b0000, 4'b0000);

      // reset values, event held high across release
      step();
      check("rst_status", st[0], 4'b0010);
      check("rst_overflow", ovf[0], 4'b0000);
      check("rst_irq", {3'b000, irq[0]}, 4'b0000);
      step();
      rst = 1'b0;
      step();
      check("held_event_after_release", st[0], 4'b0011);

      // clear everything, then single-cycle pulse on bit 2
      ev = 4'b0000;
      step();
      drive_bus(1'b1, 4'b1111, 4'b1111);
      step();
      check("clear_all", st[0], 4'b0000);
      drive_bus(1'b0, 4'b0000, 4'b0000);
      en = 4'b0100;
      ev = 4'b0100;
      step();
      check("pulse_status", st[0], 4'b0100);
      check("pulse_irq_lags", {3'b000, irq[0]}, 4'b0000);
      step();
      check("pulse_irq", {3'b000, irq[0]}, 4'b0001);
      for (int i = 0; i < 4; i++) step();
      check("held_no_change", st[0], 4'b0100);
      check("held_no_overflow", ovf[0], 4'b0000);

      // fill, then masked write-1-to-clear (cfg1 sees the matching write-0 pattern)
      ev = 4'b0000;
      step();
      ev = 4'b1111;
      step();
      check("fill_status", st[0], 4'b1111);
      ev = 4'b0000;
      drive_bus(1'b1, 4'b0101, 4'b0101);
      step();
      check("masked_clear", st[0], 4'b1010);
      check("masked_clear_cv0", st[1], 4'b1010);
      // non-clearing value written: cfg0 gets data 0000, cfg1 gets 1111
      drive_bus(1'b1, 4'b1111, 4'b0000);
      step();
      check("nonclear_write", st[0], 4'b1010);
      check("nonclear_write_cv0", st[1], 4'b1010);

      // overflow on bit 1, then clear bit 1
      drive_bus(1'b0, 4'b0000, 4'b0000);
      ev = 4'b0010;
      step();
      check("overflow_set", ovf[0], 4'b0010);
      check("overflow_status", st[0], 4'b1010);
      ev = 4'b0000;
      drive_bus(1'b1, 4'b0010, 4'b0010);
      step();
      check("overflow_clear_status", st[0], 4'b1000);
      check("overflow_clear_flag", ovf[0], 4'b0000);

      // simultaneous set and clear on bit 3
      ev = 4'b1000;
      drive_bus(1'b1, 4'b1000, 4'b1000);
      step();
      check("setclr_setwins", st[0] & 4'b1000, 4'b1000);
      check("setclr_no_overflow", ovf[0] & 4'b1000, 4'b0000);
      check("setclr_clearwins", st[1] & 4'b1000, 4'b0000);

      // build status 1011, overflow 0001, irq 1, then reset with traffic
      drive_bus(1'b0, 4'b0000, 4'b0000);
      ev = 4'b0000;
      step();
      ev = 4'b0011;
      step();
      ev = 4'b0000;
      en = 4'b1111;
      step();
      ev = 4'b0001;
      step();
      ev = 4'b0000;
      step();
      check("pre_rst_status", st[0], 4'b1011);
      check("pre_rst_overflow", ovf[0], 4'b0001);
      check("pre_rst_irq", {3'b000, irq[0]}, 4'b0001);
      rst = 1'b1;
      ev  = 4'b1111;
      drive_bus(1'b1, 4'b1111, 4'b1111);
      step();
      check("mid_rst_status", st[0], 4'b0010);
      check("mid_rst_overflow", ovf[0], 4'b0000);
      check("mid_rst_irq", {3'b000, irq[0]}, 4'b0000);
      rst = 1'b0;
      drive_bus(1'b0, 4'b0000, 4'b0000);
      ev = 4'b0000;
      step();

      // randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         rst = ($urandom_range(0, 39) == 0);
         ev  = 4'($urandom());
         en  = 4'($urandom());
         drive_bus(($urandom_range(0, 2) == 0), 4'($urandom()), 4'($urandom()));
         step();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
